tdc_delayline_ctrl: RTL and testbench

Sequencing controller for the TDC carry-chain delay line. It arms the start path, watches the registered tap word for a hit, and counts coarse clock cycles while armed. On a hit it converts the thermometer code to a fine count and hands {coarse, fine} downstream with a valid/ready handshake. It enforces a dead time so the chain flushes before re-arming, and selects between the physical trigger and a calibration trigger for code-density tests.

---
 rtl/tdc_pkg.sv | 28 ++
 rtl/tdc_delayline_ctrl_if.sv | 29 ++
 rtl/tdc_thermo_popcount.sv | 55 +++++
 rtl/tdc_delayline_ctrl.sv | 150 +++++++++++++++
 tb/tb_tdc_delayline_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC definitions: controller state encoding, constant clog2 and default
// geometry. Also used by the histogram and calibration blocks.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DEAD  = 2'd3
  } tdc_state_e;

  localparam int NTAPS_DEF    = 208;
  localparam int COARSE_W_DEF = 16;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  localparam int FINE_W_DEF = clog2(NTAPS_DEF + 1);

endpackage

// File: rtl/tdc_delayline_ctrl_if.sv
// Result handshake between the delay-line controller and its consumer.
interface tdc_delayline_ctrl_if #(
  parameter int FINE_W   = 8,
  parameter int COARSE_W = 16
);

  logic                out_valid;
  logic                out_ready;
  logic [FINE_W-1:0]   out_fine;
  logic [COARSE_W-1:0] out_coarse;
  logic                out_timeout;

  modport master (
    output out_valid,
    output out_fine,
    output out_coarse,
    output out_timeout,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_fine,
    input  out_coarse,
    input  out_timeout,
    output out_ready
  );

endinterface

// File: rtl/tdc_thermo_popcount.sv
// Thermometer-to-count conversion by popcount, which tolerates bubbles.
// Two half-sums are optionally registered before the final add.
module tdc_thermo_popcount #(
  parameter int NTAPS     = 208,
  parameter int FINE_W    = 8,
  parameter bit REG_STAGE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTAPS-1:0]  taps,
  output logic [FINE_W-1:0] fine
);

  localparam int HALF = NTAPS / 2;

  logic [FINE_W-1:0] lo_sum;
  logic [FINE_W-1:0] hi_sum;
  logic [FINE_W-1:0] lo_q;
  logic [FINE_W-1:0] hi_q;

  // Half-word population counts
  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    for (int i = 0; i < HALF; i++) begin
      lo_sum = lo_sum + FINE_W'(taps[i]);
    end
    for (int i = HALF; i < NTAPS; i++) begin
      hi_sum = hi_sum + FINE_W'(taps[i]);
    end
  end

  generate
    if (REG_STAGE) begin : g_reg
      // Pipeline register between the half sums and the final add
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lo_q <= '0;
          hi_q <= '0;
        end else begin
          lo_q <= lo_sum;
          hi_q <= hi_sum;
        end
      end
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign lo_q = lo_sum;
      assign hi_q = hi_sum;
    end
  endgenerate

  assign fine = lo_q + hi_q;

endmodule

// File: rtl/tdc_delayline_ctrl.sv
// Delay-line sequencing controller: arm, coarse count, hit/timeout capture,
// result handshake and dead time before re-arming.
module tdc_delayline_ctrl
  import tdc_pkg::*;
#(
  parameter int          NTAPS       = NTAPS_DEF,
  parameter int          COARSE_W    = COARSE_W_DEF,
  parameter int unsigned TIMEOUT     = 32'd65535,
  parameter int unsigned DEAD_CYCLES = 32'd4,
  parameter bit          POPCNT_REG  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cal_mode,
  input  logic [NTAPS-1:0] taps,
  output logic             arm,
  output logic             trigger_sel,
  output logic             busy,
  tdc_delayline_ctrl_if.master res
);

  localparam int FINE_W = clog2(NTAPS + 1);
  localparam int DEAD_W = (DEAD_CYCLES > 32'd1) ? clog2(DEAD_CYCLES) : 1;
  localparam logic [COARSE_W-1:0] TIMEOUT_C = COARSE_W'(TIMEOUT);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 32'd1);

  tdc_state_e          state;
  tdc_state_e          state_nxt;
  logic [COARSE_W-1:0] coarse;
  logic [DEAD_W-1:0]   dead_cnt;
  logic                fine_pend;
  logic [FINE_W-1:0]   pc_fine;
  logic                hit;
  logic                at_timeout;

  assign hit        = taps[0];
  assign at_timeout = (coarse == TIMEOUT_C);

  tdc_thermo_popcount #(
    .NTAPS     (NTAPS),
    .FINE_W    (FINE_W),
    .REG_STAGE (POPCNT_REG)
  ) u_popcount (
    .clk   (clk),
    .rst_n (rst_n),
    .taps  (taps),
    .fine  (pc_fine)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; enable dropping in ARMED beats a coincident hit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ARMED;
        else        state_nxt = ST_IDLE;
      end
      ST_ARMED: begin
        if (!enable)                state_nxt = ST_IDLE;
        else if (hit || at_timeout) state_nxt = ST_HOLD;
        else                        state_nxt = ST_ARMED;
      end
      ST_HOLD: begin
        if (res.out_ready && !fine_pend) state_nxt = ST_DEAD;
        else                             state_nxt = ST_HOLD;
      end
      ST_DEAD: begin
        if (dead_cnt != '0) state_nxt = ST_DEAD;
        else if (enable)    state_nxt = ST_ARMED;
        else                state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    arm           = (state == ST_ARMED);
    busy          = (state != ST_IDLE);
    res.out_valid = (state == ST_HOLD) && !fine_pend;
  end

  // Counters, trigger select and the frozen result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coarse          <= '0;
      dead_cnt        <= '0;
      fine_pend       <= 1'b0;
      trigger_sel     <= 1'b0;
      res.out_fine    <= '0;
      res.out_coarse  <= '0;
      res.out_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            trigger_sel <= cal_mode;
            coarse      <= '0;
          end
        end
        ST_ARMED: begin
          if (enable) begin
            if (hit) begin
              // With the pipelined popcount, out_fine is reloaded one cycle later
              res.out_fine    <= pc_fine;
              res.out_coarse  <= coarse;
              res.out_timeout <= 1'b0;
              fine_pend       <= POPCNT_REG;
            end else if (at_timeout) begin
              res.out_fine    <= '0;
              res.out_coarse  <= TIMEOUT_C;
              res.out_timeout <= 1'b1;
            end else begin
              coarse <= coarse + COARSE_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (fine_pend) begin
            res.out_fine <= pc_fine;
            fine_pend    <= 1'b0;
          end else if (res.out_ready) begin
            dead_cnt <= DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (dead_cnt == '0) begin
            coarse <= '0;
          end else begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
        end
        default: begin
          coarse <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_delayline_ctrl.sv
// Directed bench for tdc_delayline_ctrl (TIMEOUT = 20, DEAD_CYCLES = 4).
module tb_tdc_delayline_ctrl;
  import tdc_pkg::*;

  localparam int NTAPS    = 208;
  localparam int COARSE_W = 16;
  localparam int FINE_W   = clog2(NTAPS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             cal_mode;
  logic [NTAPS-1:0] taps;
  logic             arm;
  logic             trigger_sel;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  tdc_delayline_ctrl_if #(.FINE_W(FINE_W), .COARSE_W(COARSE_W)) res_if ();

  tdc_delayline_ctrl #(
    .NTAPS       (NTAPS),
    .COARSE_W    (COARSE_W),
    .TIMEOUT     (32'd20),
    .DEAD_CYCLES (32'd4),
    .POPCNT_REG  (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cal_mode    (cal_mode),
    .taps        (taps),
    .arm         (arm),
    .trigger_sel (trigger_sel),
    .busy        (busy),
    .res         (res_if)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NTAPS-1:0] low_ones(input int n);
    logic [NTAPS-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; cal_mode = 1'b1; taps = low_ones(9);
    res_if.out_ready = 1'b0;
    cyc(3);
    checks++;
    if ({arm, trigger_sel, busy, res_if.out_valid, res_if.out_timeout} !== 5'b0 ||
        res_if.out_fine !== '0 || res_if.out_coarse !== '0) begin
      failures++;
      $display("FAIL reset: arm=%b tsel=%b busy=%b valid=%b to=%b fine=%0d coarse=%0d, want all 0",
               arm, trigger_sel, busy, res_if.out_valid, res_if.out_timeout,
               res_if.out_fine, res_if.out_coarse);
    end
    enable = 1'b0; cal_mode = 1'b0; taps = '0;
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_hold: busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic_hit;
    enable = 1'b1;
    cyc(1);
    checks++;
    if (arm !== 1'b1 || busy !== 1'b1 || trigger_sel !== 1'b0) begin
      failures++; $display("FAIL arm_rise: arm=%b busy=%b tsel=%b want 1 1 0", arm, busy, trigger_sel);
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      checks++;
      if (arm !== 1'b1 || res_if.out_valid !== 1'b0) begin
        failures++; $display("FAIL armed_wait[%0d]: arm=%b valid=%b want 1 0", k, arm, res_if.out_valid);
      end
    end
    taps = low_ones(37);
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b1 || arm !== 1'b0 || res_if.out_coarse !== 16'd5 ||
        res_if.out_fine !== 8'd37 || res_if.out_timeout !== 1'b0) begin
      failures++;
      $display("FAIL basic_hit: valid=%b arm=%b coarse=%0d fine=%0d to=%b want 1 0 5 37 0",
               res_if.out_valid, arm, res_if.out_coarse, res_if.out_fine, res_if.out_timeout);
    end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NTAPS; i++) taps[i] = 1'($urandom_range(0, 1));
      cyc(1);
      checks++;
      if (res_if.out_valid !== 1'b1 || arm !== 1'b0 || res_if.out_fine !== 8'd37 ||
          res_if.out_coarse !== 16'd5 || res_if.out_timeout !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b arm=%b fine=%0d coarse=%0d to=%b want 1 0 37 5 0",
                 k, res_if.out_valid, arm, res_if.out_fine, res_if.out_coarse, res_if.out_timeout);
      end
    end
    taps = '0;
    res_if.out_ready = 1'b1;
    cyc(1);
    res_if.out_ready = 1'b0;
    checks++;
    if (res_if.out_valid !== 1'b0 || busy !== 1'b1 || arm !== 1'b0) begin
      failures++; $display("FAIL bp_transfer: valid=%b busy=%b arm=%b want 0 1 0", res_if.out_valid, busy, arm);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checks++;
      if (arm !== (k == 4) || res_if.out_valid !== 1'b0) begin
        failures++; $display("FAIL bp_dead[%0d]: arm=%b valid=%b want arm=%b valid=0", k, arm, res_if.out_valid, (k == 4));
      end
    end
  endtask

  task automatic test_timeout;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      checks++;
      if (res_if.out_valid !== 1'b0 || arm !== 1'b1) begin
        failures++; $display("FAIL to_wait[%0d]: valid=%b arm=%b want 0 1", k, res_if.out_valid, arm);
      end
    end
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b1 || res_if.out_timeout !== 1'b1 ||
        res_if.out_coarse !== 16'd20 || res_if.out_fine !== 8'd0) begin
      failures++;
      $display("FAIL timeout: valid=%b to=%b coarse=%0d fine=%0d want 1 1 20 0",
               res_if.out_valid, res_if.out_timeout, res_if.out_coarse, res_if.out_fine);
    end
    res_if.out_ready = 1'b1;
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL to_transfer: valid=%b want 0", res_if.out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bub;
    bub  = 16'h0F7F;
    taps = '0;
    taps[15:0] = bub;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      checks++;
      if (arm !== (k == 4)) begin
        failures++; $display("FAIL b2b_rearm[%0d]: arm=%b want %b", k, arm, (k == 4));
      end
    end
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b1 || res_if.out_fine !== 8'd11 ||
        res_if.out_coarse !== 16'd0 || res_if.out_timeout !== 1'b0) begin
      failures++;
      $display("FAIL bubble: valid=%b fine=%0d coarse=%0d to=%b want 1 11 0 0",
               res_if.out_valid, res_if.out_fine, res_if.out_coarse, res_if.out_timeout);
    end
    taps = '1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      checks++;
      if (res_if.out_valid !== (k == 6)) begin
        failures++; $display("FAIL b2b_period[%0d]: valid=%b want %b", k, res_if.out_valid, (k == 6));
      end
    end
    checks++;
    if (res_if.out_fine !== 8'd208 || res_if.out_coarse !== 16'd0) begin
      failures++; $display("FAIL full_scale: fine=%0d coarse=%0d want 208 0", res_if.out_fine, res_if.out_coarse);
    end
    taps = '0;
    cyc(1);
    res_if.out_ready = 1'b0;
  endtask

  task automatic test_enable_drop;
    cyc(4);
    checks++;
    if (arm !== 1'b1) begin
      failures++; $display("FAIL ed_armed: arm=%b want 1", arm);
    end
    enable = 1'b0;
    taps   = low_ones(10);
    cyc(1);
    checks++;
    if (busy !== 1'b0 || arm !== 1'b0 || res_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL ed_hit: busy=%b arm=%b valid=%b want 0 0 0", busy, arm, res_if.out_valid);
    end
    cyc(2);
    checks++;
    if (busy !== 1'b0 || res_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL ed_idle: busy=%b valid=%b want 0 0", busy, res_if.out_valid);
    end
    taps   = '0;
    enable = 1'b1;
    cyc(1);
    taps = low_ones(3);
    cyc(1);
    enable = 1'b0;
    taps   = '0;
    cyc(2);
    checks++;
    if (res_if.out_valid !== 1'b1 || res_if.out_fine !== 8'd3 || res_if.out_coarse !== 16'd0) begin
      failures++;
      $display("FAIL ed_hold: valid=%b fine=%0d coarse=%0d want 1 3 0",
               res_if.out_valid, res_if.out_fine, res_if.out_coarse);
    end
    res_if.out_ready = 1'b1;
    cyc(1);
    res_if.out_ready = 1'b0;
    checks++;
    if (res_if.out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL ed_transfer: valid=%b busy=%b want 0 1", res_if.out_valid, busy);
    end
    cyc(3);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL ed_dead: busy=%b want 1", busy);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || arm !== 1'b0) begin
      failures++; $display("FAIL ed_to_idle: busy=%b arm=%b want 0 0", busy, arm);
    end
  endtask

  task automatic test_reset_cal;
    cal_mode = 1'b1;
    enable   = 1'b1;
    cyc(1);
    checks++;
    if (arm !== 1'b1 || trigger_sel !== 1'b1) begin
      failures++; $display("FAIL cal_latch: arm=%b tsel=%b want 1 1", arm, trigger_sel);
    end
    cal_mode = 1'b0;
    cyc(2);
    checks++;
    if (trigger_sel !== 1'b1) begin
      failures++; $display("FAIL cal_armed: tsel=%b want 1", trigger_sel);
    end
    taps = low_ones(5);
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b1 || res_if.out_fine !== 8'd5 ||
        res_if.out_coarse !== 16'd2 || trigger_sel !== 1'b1) begin
      failures++;
      $display("FAIL cal_hit: valid=%b fine=%0d coarse=%0d tsel=%b want 1 5 2 1",
               res_if.out_valid, res_if.out_fine, res_if.out_coarse, trigger_sel);
    end
    taps = '0;
    res_if.out_ready = 1'b1;
    cyc(1);
    res_if.out_ready = 1'b0;
    cyc(4);
    checks++;
    if (arm !== 1'b1 || trigger_sel !== 1'b1) begin
      failures++; $display("FAIL cal_rearm: arm=%b tsel=%b want 1 1", arm, trigger_sel);
    end
    taps = low_ones(7);
    cyc(1);
    checks++;
    if (res_if.out_valid !== 1'b1 || res_if.out_fine !== 8'd7) begin
      failures++; $display("FAIL rst_pre: valid=%b fine=%0d want 1 7", res_if.out_valid, res_if.out_fine);
    end
    rst_n = 1'b0;
    cyc(1);
    checks++;
    if ({arm, trigger_sel, busy, res_if.out_valid, res_if.out_timeout} !== 5'b0 ||
        res_if.out_fine !== '0 || res_if.out_coarse !== '0) begin
      failures++;
      $display("FAIL rst_hold: arm=%b tsel=%b busy=%b valid=%b to=%b fine=%0d coarse=%0d, want all 0",
               arm, trigger_sel, busy, res_if.out_valid, res_if.out_timeout,
               res_if.out_fine, res_if.out_coarse);
    end
    taps  = '0;
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (arm !== 1'b1 || trigger_sel !== 1'b0 || res_if.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_restart: arm=%b tsel=%b valid=%b want 1 0 0", arm, trigger_sel, res_if.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_enable_drop();
    test_reset_cal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
